// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives the ROM PC, tracks the PC held in the ROM output register, hands (inst, pc, valid) to decode.
// Optional zero-decode jump predecode is enabled by defining INST_FETCH_JUMP_PREDECODE_EN.
module inst_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] rom_pc,
  input  logic [DATA_WIDTH-1:0] rom_inst,
  input  logic                  stall,
  input  logic                  redirect_en,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] if_inst,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic                  if_valid,
  output logic [31:0]           fetch_cnt
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_next_q, pc_next_d;
  logic [DATA_WIDTH-1:0]   pc_q;
  logic [31:0]             fetch_cnt_q, fetch_cnt_d;
  logic                    v_q;
  logic                    jump_hit;
  logic [DATA_WIDTH-1:0]   jump_tgt;

  assign v_q = (state_q == RUN);

`ifdef INST_FETCH_JUMP_PREDECODE_EN
  // J is recognised straight off the ROM output so the target is fetched with a single bubble.
  assign jump_hit = v_q & ~stall & ~redirect_en & (rom_inst[31:26] == 6'b000001);
  assign jump_tgt = {pc_q[DATA_WIDTH-1:28], rom_inst[25:0], 2'b00};
`else
  assign jump_hit = 1'b0;
  assign jump_tgt = pc_next_q;
`endif

  always_comb begin
    state_d     = RUN;
    rom_pc      = pc_next_q;
    pc_next_d   = pc_next_q;
    fetch_cnt_d = fetch_cnt_q;
    if (redirect_en)   rom_pc = redirect_pc;
    else if (stall)    rom_pc = pc_q;
    else if (jump_hit) rom_pc = jump_tgt;
    if (!stall || redirect_en) pc_next_d = rom_pc + DATA_WIDTH'(4);
    if (if_valid && !stall)    fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  assign if_inst   = rom_inst;
  assign if_pc     = pc_q;
  assign if_valid  = v_q & ~redirect_en & ~jump_hit;
  assign fetch_cnt = fetch_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_next_q   <= RESET_PC;
      pc_q        <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_next_q   <= pc_next_d;
      pc_q        <= rom_pc;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a driver issues stall/redirect/reset and queues the PCs decode should receive; a monitor checks them.
module tb_inst_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_pc;
  logic [31:0] rom_inst;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] fetch_cnt;

  logic [31:0] mem [256];
  logic [31:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;

  inst_fetch #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .rom_pc(rom_pc), .rom_inst(rom_inst),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle latency, word-indexed by pc[9:2].
  always @(posedge clk) rom_inst <= mem[rom_pc[9:2]];

  function automatic logic is_j(input logic [31:0] w);
    return w[31:26] == 6'b000001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order stream decode must consume, starting at t.
  task automatic push_stream(input logic [31:0] t);
    logic [31:0] p;
    exp_q.delete();
    p = t;
    for (int i = 0; i < 64; i++) begin
`ifdef INST_FETCH_JUMP_PREDECODE_EN
      for (int k = 0; k < 8 && is_j(mem[p[9:2]]); k++)
        p = {p[31:28], mem[p[9:2]][25:0], 2'b00};
`endif
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // Monitor
  int          since = 0;
  logic [31:0] cnt   = '0;
  always begin
    logic        jh, ev;
    logic [31:0] p;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      check("rst_valid", {31'd0, if_valid}, 32'd0);
      check("rst_cnt", fetch_cnt, 32'd0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_rom_pc", rom_pc, RST_PC);
      since = 0;
      cnt   = '0;
    end else begin
      jh = 1'b0;
`ifdef INST_FETCH_JUMP_PREDECODE_EN
      jh = (since > 0) && !stall && !redirect_en && is_j(rom_inst);
`endif
      ev = (since > 0) && !redirect_en && !jh;
      check("if_valid", {31'd0, if_valid}, {31'd0, ev});
      check("fetch_cnt", fetch_cnt, cnt);
      if (redirect_en)
        check("rom_pc_redirect", rom_pc, redirect_pc);
      else if (stall && since > 0)
        check("rom_pc_replay", rom_pc, if_pc);
      else if (jh)
        check("rom_pc_jump", rom_pc, {if_pc[31:28], rom_inst[25:0], 2'b00});
      if (ev) begin
        if (exp_q.size() == 0) begin
          check("queue_empty", 32'd1, 32'd0);
        end else if (stall) begin
          check("stalled_pc", if_pc, exp_q[0]);
          check("stalled_inst", if_inst, mem[exp_q[0][9:2]]);
        end else begin
          p = exp_q.pop_front();
          check("if_pc", if_pc, p);
          check("if_inst", if_inst, mem[p[9:2]]);
          check("rom_pc_seq", rom_pc, p + 32'd4);
          cnt = cnt + 32'd1;
        end
      end
      if (since < 2) since++;
    end
  end

  task automatic cyc(input logic s, input logic r, input logic [31:0] t);
    @(negedge clk);
    stall       = s;
    redirect_en = r;
    redirect_pc = t;
    if (r) push_stream(t);
  endtask

  initial begin
    int          since_redir;
    logic        s, r;
    logic [31:0] t;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      if (is_j(mem[i])) mem[i][31] = 1'b1;
    end
    mem[12] = {6'b000001, 26'd15};  // J 15 at 0x30 -> 0x3c
    rst_n = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_stream(RST_PC);

    // Directed: stall at 0x18, J at 0x30, stall+redirect together.
    for (int j = 1; j <= 30; j++) begin
      s = (j == 7 || j == 8) || (j == 22);
      r = 1'b0; t = '0;
`ifndef INST_FETCH_JUMP_PREDECODE_EN
      if (j == 16) begin r = 1'b1; t = 32'h3c; end
`endif
      if (j == 22) begin r = 1'b1; t = 32'h3c; end
      if (j == 27) begin r = 1'b1; t = 32'h24; end
      cyc(s, r, t);
    end

    since_redir = 0;
    for (int n = 0; n < 500; n++) begin
      if (n == 250) begin
        @(negedge clk);
        stall = 1'b0; redirect_en = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_stream(RST_PC);
        since_redir = 0;
        continue;
      end
      s = ($urandom_range(3) == 0);
      r = ($urandom_range(7) == 0) || (since_redir >= 40);
      t = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(15))
        0: t = 32'hFFFF_FFF4;
        1: t = t | 32'($urandom_range(3));
        2: t = 32'h0000_0028;
        default: ;
      endcase
      since_redir = r ? 0 : since_redir + 1;
      cyc(s, r, t);
    end

    cyc(1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
